frame_buffer_ctrl: RTL and testbench
====================================

FRAME_BUFFER_CTRL -- requirements
Module: frame_buffer_ctrl

Interface
REQ-001 Parameter DATA_W, 16, pixel word width.
REQ-002 Parameter BANK_AW, 15, per-bank address width; RAM address = {bank, offset}, BANK_AW+1 bits.
REQ-003 Parameter FRAME_LEN, 32768, words per frame, 1..2**BANK_AW.
REQ-004 Parameter RD_LAT, 2, RAM read latency in cycles, 1..3.
REQ-005 One clock; reset is synchronous and active-high: clk in 1 system clock; rst in 1 synchronous active-high reset.
REQ-006 wr_valid in 1, wr_sof in 1, wr_data in DATA_W, wr_ready out 1: producer stream; beat accepted when wr_valid&&wr_ready.
REQ-007 rd_start in 1: pulse requesting playback of the next complete frame.
REQ-008 rd_valid out 1, rd_data out DATA_W, rd_last out 1, rd_ready in 1: consumer stream; beat transferred when rd_valid&&rd_ready.
REQ-009 ram_wren out 1, ram_waddr out BANK_AW+1, ram_wdata out DATA_W, ram_raddr out BANK_AW+1, ram_rdata in DATA_W: dual-port RAM, both ports on clk.
REQ-010 frame_avail out 1, high while a full bank awaits reading; rd_underrun out 1, one-cycle pulse.

Function
REQ-011 Two banks; state wb (write bank), rb (read bank), full[1:0].
REQ-012 wr_ready = !full[wb] && !rst; each accepted beat drives ram_wren=1, ram_waddr={wb,wcnt}, ram_wdata=wr_data in the same cycle (combinational), wcnt++.
REQ-013 Accepted beat with wr_sof=1 writes offset 0 and sets wcnt=1, discarding any partial frame.
REQ-014 Beat accepted at wcnt==FRAME_LEN-1 completes the frame: full[wb]<=1, wb<=~wb, wcnt<=0.
REQ-015 Reader FSM R_IDLE, R_FETCH, R_DRAIN; R_IDLE on rd_start: full[rb] -> R_FETCH, rcnt=0; else pulse rd_underrun, stay.
REQ-016 R_FETCH issues ram_raddr={rb,rcnt}, rcnt++, only when inflight+fifo_count < 4; after issuing offset FRAME_LEN-1 -> R_DRAIN.
REQ-017 Read data returns RD_LAT cycles after issue into a 4-entry FIFO; tag of last address travels with data and drives rd_last.
REQ-018 R_DRAIN -> R_IDLE on the transfer with rd_last=1; in that cycle full[rb]<=0, rb<=~rb.
REQ-019 rd_start outside R_IDLE ignored, no underrun pulse.
REQ-020 Simultaneous frame completion (writer) and frame release (reader) act on different banks; both updates apply same cycle.
REQ-021 Writer completing into the bank rb is legal; reader sees it on next rd_start.
REQ-022 rd_valid = FIFO non-empty; data order equals address order; no beat lost or duplicated under any rd_ready pattern.
REQ-023 frame_avail = full[rb] && state==R_IDLE, registered.

Reset
REQ-024 On rst: wb=0, rb=0, full=0, wcnt=0, rcnt=0, FSM R_IDLE, FIFO and inflight pipeline flushed.
REQ-025 During and first cycle after rst: wr_ready=0, ram_wren=0, rd_valid=0, rd_last=0, rd_underrun=0, frame_avail=0, ram_raddr=0.
REQ-026 rst mid-frame discards partial write and in-progress read; data returning from pre-reset reads is dropped.

Configuration
REQ-027 Macro FRAME_BUFFER_STATS_EN: defined -> outputs stat_frames[15:0] (completed writes) and stat_underruns[15:0], wrapping 0xFFFF->0, cleared by rst; undefined -> ports and counters absent, behaviour otherwise identical.

Structure
REQ-028 Package fb_pkg holds reader state enum, FIFO depth constant 4, default parameter values.
REQ-029 Sub-module fb_rd_fifo: 4-entry synchronous FIFO, {last, data}, push/pop/count.

Verification (FRAME_LEN=8, RD_LAT=2, RAM model included)
REQ-030 Write frame 0..7, rd_start, rd_ready=1 -> rd_data 0..7 consecutive, rd_last on 7, full[0] clears, rb=1.
REQ-031 rd_start with no full bank -> rd_underrun one cycle, no ram reads, state stays R_IDLE.
REQ-032 Write two frames (0..7, 8..15) without reading -> wr_ready=0 after 16th beat; one frame read -> wr_ready=1 next cycle.
REQ-033 rd_ready toggled 1/0 every cycle and random -> output 0..7 exact, FIFO never overflows.
REQ-034 wr_sof at beat 3 of frame -> frame completes 8 beats after sof; read returns the post-sof data.
REQ-035 rst asserted mid-read (after beat 4) -> rd_valid=0 next cycle, no stale data after release; with FRAME_BUFFER_STATS_EN, stat counters read 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the double-buffered frame controller.
package fb_pkg;
    localparam int FB_DATA_W     = 16;
    localparam int FB_BANK_AW    = 15;
    localparam int FB_FRAME_LEN  = 32768;
    localparam int FB_RD_LAT     = 2;

    localparam int FB_FIFO_DEPTH = 4;
    localparam int FB_CNT_W      = $clog2(FB_FIFO_DEPTH + 1);
    localparam int FB_PTR_W      = $clog2(FB_FIFO_DEPTH);

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DRAIN
    } rd_state_e;
endpackage

// File: rtl/fb_rd_fifo.sv
// Small return-data FIFO for the reader; each entry is {last, data}.
module fb_rd_fifo
    import fb_pkg::*;
#(
    parameter int W = FB_DATA_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [W-1:0]        din,
    input  logic                pop,
    output logic [W-1:0]        dout,
    output logic                empty,
    output logic [FB_CNT_W-1:0] count
);
    logic [W-1:0]        mem [FB_FIFO_DEPTH];
    logic [FB_PTR_W-1:0] wp, rp;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + FB_PTR_W'(1);
            if (pop)  rp <= rp + FB_PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + FB_CNT_W'(1);
                2'b01:   count <= count - FB_CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    assign dout  = mem[rp];
    assign empty = (count == '0);
endmodule

// File: rtl/frame_buffer_ctrl.sv
// Two-bank frame buffer: producer fills one bank while consumer plays the other.
// Optional statistics counters: define FRAME_BUFFER_STATS_EN.
module frame_buffer_ctrl
    import fb_pkg::*;
#(
    parameter int DATA_W    = FB_DATA_W,
    parameter int BANK_AW   = FB_BANK_AW,
    parameter int FRAME_LEN = FB_FRAME_LEN,
    parameter int RD_LAT    = FB_RD_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    input  logic               wr_sof,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_ready,
    input  logic               rd_start,
    output logic               rd_valid,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_last,
    input  logic               rd_ready,
    output logic               ram_wren,
    output logic [BANK_AW:0]   ram_waddr,
    output logic [DATA_W-1:0]  ram_wdata,
    output logic [BANK_AW:0]   ram_raddr,
    input  logic [DATA_W-1:0]  ram_rdata,
    output logic               frame_avail,
    output logic               rd_underrun
`ifdef FRAME_BUFFER_STATS_EN
    ,
    output logic [15:0]        stat_frames,
    output logic [15:0]        stat_underruns
`endif
);
    localparam logic [BANK_AW-1:0] LAST_OFF = BANK_AW'(FRAME_LEN - 1);

    logic                wb, rb, rb_nxt, out_en;
    logic [1:0]          full, full_nxt;
    logic [BANK_AW-1:0]  wcnt, rcnt, woff;
    rd_state_e           state, state_nxt;
    logic [RD_LAT:1]     vld_pipe, last_pipe;
    logic [FB_CNT_W-1:0] fifo_count, inflight;
    logic                wr_acc, wr_done, rd_done, issue, pop;
    logic                fifo_empty, fifo_last, underrun_nxt, underrun_q, avail_q;

    // out_en keeps the write port closed for the first cycle after reset
    assign wr_ready  = !rst && out_en && !full[wb];
    assign wr_acc    = wr_valid && wr_ready;
    assign woff      = wr_sof ? '0 : wcnt;
    assign wr_done   = wr_acc && (woff == LAST_OFF);
    assign ram_wren  = wr_acc;
    assign ram_waddr = {wb, woff};
    assign ram_wdata = wr_data;
    assign ram_raddr = rst ? '0 : {rb, rcnt};

    always_comb begin
        inflight = '0;
        for (int k = 1; k <= RD_LAT; k++) inflight = inflight + FB_CNT_W'(vld_pipe[k]);
    end

    // Credit check keeps FIFO + in-flight reads within the FIFO depth
    assign issue = (state == R_FETCH) &&
                   (({1'b0, inflight} + {1'b0, fifo_count}) < (FB_CNT_W + 1)'(FB_FIFO_DEPTH));

    assign rd_valid    = !rst && !fifo_empty;
    assign rd_last     = rd_valid && fifo_last;
    assign pop         = rd_valid && rd_ready;
    assign rd_done     = (state == R_DRAIN) && pop && fifo_last;
    assign rb_nxt      = rd_done ? ~rb : rb;
    assign rd_underrun = !rst && underrun_q;
    assign frame_avail = !rst && avail_q;

    always_comb begin
        state_nxt    = state;
        underrun_nxt = 1'b0;
        case (state)
            R_IDLE: begin
                if (rd_start) begin
                    if (full[rb]) state_nxt = R_FETCH;
                    else          underrun_nxt = 1'b1;
                end
            end
            R_FETCH: if (issue && rcnt == LAST_OFF) state_nxt = R_DRAIN;
            R_DRAIN: if (rd_done) state_nxt = R_IDLE;
            default: state_nxt = R_IDLE;
        endcase
    end

    // Writer and reader always touch different banks when both fire
    always_comb begin
        full_nxt = full;
        if (rd_done) full_nxt[rb] = 1'b0;
        if (wr_done) full_nxt[wb] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_en     <= 1'b0;
            state      <= R_IDLE;
            wb         <= 1'b0;
            rb         <= 1'b0;
            full       <= '0;
            wcnt       <= '0;
            rcnt       <= '0;
            underrun_q <= 1'b0;
            avail_q    <= 1'b0;
            vld_pipe   <= '0;
            last_pipe  <= '0;
        end else begin
            out_en     <= 1'b1;
            state      <= state_nxt;
            full       <= full_nxt;
            rb         <= rb_nxt;
            underrun_q <= underrun_nxt;
            avail_q    <= full_nxt[rb_nxt] && (state_nxt == R_IDLE);
            if (wr_acc)  wcnt <= wr_done ? '0 : woff + BANK_AW'(1);
            if (wr_done) wb   <= ~wb;
            if (state == R_IDLE) rcnt <= '0;
            else if (issue)      rcnt <= rcnt + BANK_AW'(1);
            vld_pipe[1]  <= issue;
            last_pipe[1] <= issue && (rcnt == LAST_OFF);
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                last_pipe[k] <= last_pipe[k-1];
            end
        end
    end

    fb_rd_fifo #(.W(DATA_W + 1)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_pipe[RD_LAT]),
        .din   ({last_pipe[RD_LAT], ram_rdata}),
        .pop   (pop),
        .dout  ({fifo_last, rd_data}),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef FRAME_BUFFER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames    <= '0;
            stat_underruns <= '0;
        end else begin
            if (wr_done)      stat_frames    <= stat_frames + 16'd1;
            if (underrun_nxt) stat_underruns <= stat_underruns + 16'd1;
        end
    end
`else
    // statistics counters compiled out
`endif
endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl with a small RD_LAT=2 dual-port RAM model.
module tb_frame_buffer_ctrl;
    import fb_pkg::*;

    localparam int DW  = 16;
    localparam int BAW = 3;
    localparam int FL  = 8;
    localparam int RL  = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wr_valid = 1'b0, wr_sof = 1'b0, wr_ready;
    logic [DW-1:0]  wr_data = '0;
    logic           rd_start = 1'b0, rd_ready = 1'b0;
    logic           rd_valid, rd_last;
    logic [DW-1:0]  rd_data;
    logic           ram_wren;
    logic [BAW:0]   ram_waddr, ram_raddr;
    logic [DW-1:0]  ram_wdata, ram_rdata;
    logic           frame_avail, rd_underrun;
`ifdef FRAME_BUFFER_STATS_EN
    logic [15:0]    stat_frames, stat_underruns;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    frame_buffer_ctrl #(.DATA_W(DW), .BANK_AW(BAW), .FRAME_LEN(FL), .RD_LAT(RL)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_sof(wr_sof), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_start(rd_start),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
        .ram_wren(ram_wren), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .frame_avail(frame_avail), .rd_underrun(rd_underrun)
`ifdef FRAME_BUFFER_STATS_EN
        , .stat_frames(stat_frames), .stat_underruns(stat_underruns)
`endif
    );

    // RAM model: two-stage registered read path
    logic [DW-1:0] mem [0:(1<<(BAW+1))-1];
    logic [DW-1:0] rp1, rp2;
    always @(posedge clk) begin
        if (ram_wren) mem[ram_waddr] <= ram_wdata;
        rp1 <= mem[ram_raddr];
        rp2 <= rp1;
    end
    assign ram_rdata = rp2;

    task automatic write_beat(input int d, input logic sof);
        int t = 0;
        @(negedge clk);
        wr_valid = 1'b1; wr_data = DW'(d); wr_sof = sof;
        #1;
        while (!wr_ready && t < 50) begin
            @(negedge clk); #1; t++;
        end
        checks++;
        if (!wr_ready) begin
            errors++;
            $display("FAIL write_timeout: wr_ready=%0b required 1 for data %0d", wr_ready, d);
        end
        @(posedge clk); #1;
        wr_valid = 1'b0; wr_sof = 1'b0;
    endtask

    task automatic write_frame(input int base);
        for (int i = 0; i < FL; i++) write_beat(base + i, 1'b0);
    endtask

    // mode 0: ready always, 1: toggle, 2: random. Returns at the negedge after the last transfer.
    task automatic read_frame(input int base, input int mode, input int nbeats);
        int  idx = 0;
        int  t = 0;
        logic ovf = 1'b0;
        @(negedge clk); rd_start = 1'b1;
        @(negedge clk); rd_start = 1'b0;
        while (idx < nbeats && t < 300) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = t[0];
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (dut.u_fifo.count > 3'd4) ovf = 1'b1;
            if (rd_valid && rd_ready) begin
                checks++;
                if (rd_data !== DW'(base + idx) || rd_last !== (idx == FL - 1)) begin
                    errors++;
                    $display("FAIL read_beat%0d: data=%0d last=%0b required data=%0d last=%0b",
                             idx, rd_data, rd_last, base + idx, (idx == FL - 1));
                end
                idx++;
            end
            @(negedge clk); t++;
        end
        checks++;
        if (idx != nbeats || ovf) begin
            errors++;
            $display("FAIL read_count: beats=%0d overflow=%0b required beats=%0d overflow=0",
                     idx, ovf, nbeats);
        end
    endtask

    task automatic test_reset;
        wr_valid = 1'b1; wr_data = 16'h55AA;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({wr_ready, ram_wren, rd_valid, rd_last, rd_underrun, frame_avail} !== 6'b0 || ram_raddr !== '0) begin
            errors++;
            $display("FAIL reset_during: outs=%b raddr=%0d required all 0",
                     {wr_ready, ram_wren, rd_valid, rd_last, rd_underrun, frame_avail}, ram_raddr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({wr_ready, ram_wren, rd_valid, rd_last, rd_underrun, frame_avail} !== 6'b0 || ram_raddr !== '0) begin
            errors++;
            $display("FAIL reset_after: outs=%b raddr=%0d required all 0",
                     {wr_ready, ram_wren, rd_valid, rd_last, rd_underrun, frame_avail}, ram_raddr);
        end
        wr_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_wr_ready_open: got %0b required 1", wr_ready);
        end
    endtask

    task automatic test_underrun;
        @(negedge clk); rd_start = 1'b1;
        @(negedge clk); rd_start = 1'b0; #1;
        checks++;
        if (rd_underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_pulse: got %0b required 1", rd_underrun);
        end
        @(negedge clk); #1;
        checks++;
        if (rd_underrun !== 1'b0 || rd_valid !== 1'b0 || dut.state !== R_IDLE || ram_raddr !== '0) begin
            errors++;
            $display("FAIL underrun_after: underrun=%0b valid=%0b state=%0d raddr=%0d required 0 0 0 0",
                     rd_underrun, rd_valid, dut.state, ram_raddr);
        end
    endtask

    task automatic test_basic;
        write_frame(0);
        checks++;
        if (frame_avail !== 1'b1) begin
            errors++;
            $display("FAIL basic_avail: got %0b required 1", frame_avail);
        end
        read_frame(0, 0, FL);
        checks++;
        if (dut.full !== 2'b00 || dut.rb !== 1'b1 || frame_avail !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: full=%b rb=%0b avail=%0b valid=%0b required 00 1 0 0",
                     dut.full, dut.rb, frame_avail, rd_valid);
        end
    endtask

    task automatic test_full;
        write_frame(8);
        write_frame(16);
        #1;
        checks++;
        if (wr_ready !== 1'b0 || dut.full !== 2'b11) begin
            errors++;
            $display("FAIL full_block: wr_ready=%0b full=%b required 0 11", wr_ready, dut.full);
        end
        read_frame(8, 0, FL);
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_reopen: wr_ready=%0b required 1", wr_ready);
        end
    endtask

    task automatic test_toggle;
        read_frame(16, 1, FL);
        checks++;
        if (dut.full !== 2'b00 || dut.rb !== 1'b1) begin
            errors++;
            $display("FAIL toggle_release: full=%b rb=%0b required 00 1", dut.full, dut.rb);
        end
    endtask

    task automatic test_sof;
        for (int i = 0; i < 3; i++) write_beat(100 + i, 1'b0);
        write_beat(200, 1'b1);
        for (int i = 1; i < FL - 1; i++) write_beat(200 + i, 1'b0);
        checks++;
        if (dut.full[1] !== 1'b0) begin
            errors++;
            $display("FAIL sof_early: full[1]=%0b required 0", dut.full[1]);
        end
        write_beat(200 + FL - 1, 1'b0);
        checks++;
        if (dut.full[1] !== 1'b1) begin
            errors++;
            $display("FAIL sof_complete: full[1]=%0b required 1", dut.full[1]);
        end
        read_frame(200, 2, FL);
    endtask

    task automatic test_random;
        write_frame(300);
        read_frame(300, 2, FL);
    endtask

    task automatic test_back_to_back;
        write_frame(400);
        fork
            read_frame(400, 0, FL);
            begin
                repeat (4) @(negedge clk);
                write_frame(500);
            end
        join
        checks++;
        if (dut.full !== 2'b01 || dut.rb !== 1'b0 || dut.wb !== 1'b1) begin
            errors++;
            $display("FAIL b2b_state: full=%b rb=%0b wb=%0b required 01 0 1", dut.full, dut.rb, dut.wb);
        end
        read_frame(500, 0, FL);
    endtask

    task automatic test_reset_mid_read;
        int stale = 0;
        write_frame(600);
`ifdef FRAME_BUFFER_STATS_EN
        checks++;
        if (stat_frames !== 16'd8 || stat_underruns !== 16'd1) begin
            errors++;
            $display("FAIL stats_count: frames=%0d underruns=%0d required 8 1", stat_frames, stat_underruns);
        end
`endif
        read_frame(600, 0, 4);
        rst = 1'b1; #1;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid: got %0b required 0", rd_valid);
        end
        @(negedge clk);
        rst = 1'b0; #1;
        checks++;
        if ({wr_ready, rd_valid, rd_last, rd_underrun, frame_avail} !== 5'b0 || ram_raddr !== '0) begin
            errors++;
            $display("FAIL midrst_after: outs=%b raddr=%0d required all 0",
                     {wr_ready, rd_valid, rd_last, rd_underrun, frame_avail}, ram_raddr);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (rd_valid) stale++;
        end
        checks++;
        if (stale != 0 || dut.full !== 2'b00) begin
            errors++;
            $display("FAIL midrst_stale: stale_beats=%0d full=%b required 0 00", stale, dut.full);
        end
`ifdef FRAME_BUFFER_STATS_EN
        checks++;
        if (stat_frames !== 16'd0 || stat_underruns !== 16'd0) begin
            errors++;
            $display("FAIL stats_clear: frames=%0d underruns=%0d required 0 0", stat_frames, stat_underruns);
        end
`endif
        rd_ready = 1'b0;
        write_frame(700);
        read_frame(700, 1, FL);
    endtask

    initial begin
        test_reset;
        test_underrun;
        test_basic;
        test_full;
        test_toggle;
        test_sof;
        test_random;
        test_back_to_back;
        test_reset_mid_read;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
